// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the fetch-controller state encoding, the datapath word width
// and the program counter value loaded at reset.
package cpu_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2,
        HALTED  = 2'd3
    } state_t;
endpackage

// File: rtl/inc16.sv
// Shared 16-bit incrementer: computes a + 1 modulo 2^16 and reports the carry-out.
module inc16 (
    input  logic [15:0] a,
    output logic [15:0] sum,
    output logic        co
);
    always_comb begin
        {co, sum} = {1'b0, a} + 17'd1;
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch controller: runs the req/ack fetch toward imem
// and hands each fetched word to the decoder through a valid/ready handshake.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int               WIDTH      = WORD_W,
    parameter logic [WIDTH-1:0] RESET_ADDR = PC_RESET
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             halt,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] pc,
    output logic             pc_wrap
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pend_addr_q, pend_addr_d;
    logic             pend_q, pend_d, req_q, req_d, valid_q, valid_d, wrap_q, wrap_d;
    logic [WIDTH-1:0] inc_sum;
    logic             inc_co;

    inc16 u_inc (
        .a   (pc_q),
        .sum (inc_sum),
        .co  (inc_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_ADDR;
            instr_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        req_d       = 1'b0;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                // An ack is only meaningful while the request is actually up; during the
                // one-cycle gap after a discarded fetch it is ignored.
                if (req_q && imem_ack) begin
                    if (pend_q || load) begin
                        pc_d   = load ? load_addr : pend_addr_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d = imem_data;
                        pc_d    = inc_sum;
                        wrap_d  = inc_co;
                        valid_d = 1'b1;
                        state_d = DELIVER;
                    end
                end else begin
                    req_d = 1'b1;
                    if (load) begin
                        pend_d      = 1'b1;
                        pend_addr_d = load_addr;
                    end
                end
            end
            DELIVER: begin
                if (instr_ready) begin
                    if (load) pc_d = load_addr;
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end
                end else if (load) begin
                    pc_d    = load_addr;
                    state_d = FETCH;
                    req_d   = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            HALTED: begin
                if (load) pc_d = load_addr;
                if (!halt) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_wrap     = wrap_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a behavioural instruction memory plus a queue of
// expected delivered words, checked with immediate assertions.
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_addr = 16'h0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready = 1'b0;
    logic [15:0] pc;
    logic        pc_wrap;

    int passed = 0;
    int failed = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    assign imem_data = memf(imem_addr);

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_addr   (load_addr),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_wrap     (pc_wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            failed++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, instr, e);
        end
    endtask

    // In FETCH with the request up: ack it and land in DELIVER.
    task automatic fetch_one(input string tag, input logic [15:0] a);
        chk({tag, "_req"}, {15'd0, imem_req}, 16'd1);
        chk({tag, "_addr"}, imem_addr, a);
        imem_ack = 1'b1;
        exp_q.push_back(memf(a));
        tick();
        imem_ack = 1'b0;
        chk({tag, "_valid"}, {15'd0, instr_valid}, 16'd1);
        pop_chk({tag, "_instr"});
        chk({tag, "_reqlow"}, {15'd0, imem_req}, 16'd0);
        chk({tag, "_pc"}, pc, a + 16'd1);
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_wrap", {15'd0, pc_wrap}, 16'd0);
        rst_n = 1'b1;
        tick();

        // ack and ready tied high: back-to-back fetch/deliver
        imem_ack = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("tied_req", {15'd0, imem_req}, 16'd1);
            chk("tied_addr", imem_addr, 16'(k));
            chk("tied_vlow", {15'd0, instr_valid}, 16'd0);
            exp_q.push_back(memf(16'(k)));
            tick();
            chk("tied_valid", {15'd0, instr_valid}, 16'd1);
            pop_chk("tied_instr");
            chk("tied_pc", pc, 16'(k + 1));
            tick();
        end
        imem_ack = 1'b0;
        instr_ready = 1'b0;

        // redirect during an outstanding request with a slow ack
        load = 1'b1;
        load_addr = 16'h1234;
        tick();
        load = 1'b0;
        chk("rd_hold0", imem_addr, 16'h0003);
        tick();
        chk("rd_hold1", imem_addr, 16'h0003);
        chk("rd_reqhold", {15'd0, imem_req}, 16'd1);
        tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("rd_drop_req", {15'd0, imem_req}, 16'd0);
        chk("rd_drop_valid", {15'd0, instr_valid}, 16'd0);
        chk("rd_pc", pc, 16'h1234);
        tick();
        fetch_one("rd_fetch", 16'h1234);
        consume();

        // wrap from 0xFFFF to 0x0000
        load = 1'b1;
        load_addr = 16'hFFFF;
        tick();
        load = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("wr_pc", pc, 16'hFFFF);
        tick();
        fetch_one("wr_f0", 16'hFFFF);
        chk("wr_wrap1", {15'd0, pc_wrap}, 16'd1);
        consume();
        chk("wr_wrap0", {15'd0, pc_wrap}, 16'd0);
        fetch_one("wr_f1", 16'h0000);
        chk("wr_wrap2", {15'd0, pc_wrap}, 16'd0);
        consume();

        // load in DELIVER without ready flushes, with ready consumes
        fetch_one("dl_f0", 16'h0001);
        load = 1'b1;
        load_addr = 16'h0040;
        tick();
        load = 1'b0;
        chk("dl_flush_valid", {15'd0, instr_valid}, 16'd0);
        chk("dl_flush_pc", pc, 16'h0040);
        fetch_one("dl_f1", 16'h0040);
        load = 1'b1;
        instr_ready = 1'b1;
        tick();
        load = 1'b0;
        instr_ready = 1'b0;
        chk("dl_acc_valid", {15'd0, instr_valid}, 16'd0);
        chk("dl_acc_req", {15'd0, imem_req}, 16'd1);
        chk("dl_acc_addr", imem_addr, 16'h0040);

        // halt at consume; stray acks while halted are ignored
        fetch_one("ht_f0", 16'h0040);
        halt = 1'b1;
        consume();
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("ht_noreq", {15'd0, imem_req}, 16'd0);
            chk("ht_pc", pc, 16'h0041);
            tick();
        end
        imem_ack = 1'b0;
        halt = 1'b0;
        tick();
        chk("ht_rel_req", {15'd0, imem_req}, 16'd1);
        chk("ht_rel_addr", imem_addr, 16'h0041);

        // asynchronous reset while a request is up
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_req", {15'd0, imem_req}, 16'd0);
        chk("ar_pc", pc, 16'h0000);
        imem_ack = 1'b1;
        tick();
        chk("ar_req2", {15'd0, imem_req}, 16'd0);
        chk("ar_valid", {15'd0, instr_valid}, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("ar_boot_req", {15'd0, imem_req}, 16'd1);
        chk("ar_boot_addr", imem_addr, 16'h0000);
        chk("ar_boot_valid", {15'd0, instr_valid}, 16'd0);
        imem_ack = 1'b0;
        chk("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end
endmodule
